// File: rtl/exc_commit_ctrl.sv
// Precise exception / interrupt / ERET commit sequencer between WB, CP0 and fetch.
// Optional build macro EXC_CNT_EN enables the saturating accepted-exception counter on exc_count.
module exc_commit_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_ex,
    input  logic [4:0]  wb_excode,
    input  logic [31:0] wb_pc,
    input  logic        wb_bd,
    input  logic [31:0] wb_badvaddr,
    input  logic        wb_eret,
    input  logic [31:0] cp0_status,
    input  logic [7:0]  cp0_cause_ip,
    input  logic [31:0] cp0_epc,
    output logic        cp0_ex_we,
    output logic        cp0_eret_we,
    output logic [4:0]  cp0_excode,
    output logic        cp0_bd,
    output logic [31:0] cp0_epc_wdata,
    output logic        cp0_badv_we,
    output logic [31:0] cp0_badvaddr,
    output logic        pipeline_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy,
    output logic [31:0] exc_count
);

    typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  flush_cnt;
    logic        int_pending;
    logic        accept_exc;
    logic        accept_eret;
    logic        badv_sel;
    logic [4:0]  excode_sel;
    logic        unused_status;

    assign unused_status = &{1'b0, cp0_status[31:16], cp0_status[7:2]};

    // Interrupts only ride on a committing WB instruction, and outrank its own exception.
    assign int_pending = cp0_status[0] & ~cp0_status[1] & (|(cp0_cause_ip & cp0_status[15:8]));
    assign accept_exc  = (state == IDLE) & wb_valid & (int_pending | wb_ex);
    assign accept_eret = (state == IDLE) & wb_valid & ~int_pending & ~wb_ex & wb_eret;
    assign excode_sel  = int_pending ? 5'h00 : wb_excode;
    assign badv_sel    = ~int_pending & ((wb_excode == 5'd4) | (wb_excode == 5'd5));

    // ---- state register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt <= 4'd0;
        end else if (accept_exc | accept_eret) begin
            flush_cnt <= FLUSH_LOAD;
        end else if ((state == FLUSH) && (flush_cnt != 4'd0)) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept_exc | accept_eret) state_nxt = FLUSH;
            FLUSH:    if (flush_cnt == 4'd0)        state_nxt = REDIRECT;
            REDIRECT: if (redirect_ready)           state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    // ---- state-decoded outputs ----
    always_comb begin
        pipeline_flush = (state == FLUSH);
        redirect_valid = (state == REDIRECT);
        busy           = (state != IDLE);
    end

    // ---- CP0 commit registers, visible the cycle after accept ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cp0_ex_we     <= 1'b0;
            cp0_eret_we   <= 1'b0;
            cp0_badv_we   <= 1'b0;
            cp0_excode    <= 5'd0;
            cp0_bd        <= 1'b0;
            cp0_epc_wdata <= 32'd0;
            cp0_badvaddr  <= 32'd0;
            redirect_pc   <= 32'd0;
        end else begin
            cp0_ex_we   <= accept_exc;
            cp0_eret_we <= accept_eret;
            cp0_badv_we <= accept_exc & badv_sel;
            if (accept_exc) begin
                cp0_excode    <= excode_sel;
                cp0_bd        <= wb_bd;
                cp0_epc_wdata <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
                redirect_pc   <= EXC_VECTOR;
                if (badv_sel) begin
                    cp0_badvaddr <= wb_badvaddr;
                end
            end else if (accept_eret) begin
                redirect_pc <= cp0_epc;
            end
        end
    end

`ifdef EXC_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    logic [31:0] exc_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_count_q <= 32'd0;
        end else if (accept_exc) begin
            exc_count_q <= sat_inc(exc_count_q);
        end
    end

    assign exc_count = exc_count_q;
`else
    assign exc_count = 32'h0;
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl: expected CP0 commits and redirects are queued
// when an event is driven and checked when the DUT strobes / completes the handshake.
module tb_exc_commit_ctrl;

    localparam int          FC  = 2;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ex = 1'b0;
    logic [4:0]  wb_excode = 5'd0;
    logic [31:0] wb_pc = 32'd0;
    logic        wb_bd = 1'b0;
    logic [31:0] wb_badvaddr = 32'd0;
    logic        wb_eret = 1'b0;
    logic [31:0] cp0_status = 32'd0;
    logic [7:0]  cp0_cause_ip = 8'd0;
    logic [31:0] cp0_epc = 32'd0;
    logic        redirect_ready = 1'b0;
    logic        cp0_ex_we, cp0_eret_we, cp0_bd, cp0_badv_we;
    logic [4:0]  cp0_excode;
    logic [31:0] cp0_epc_wdata, cp0_badvaddr, redirect_pc, exc_count;
    logic        pipeline_flush, redirect_valid, busy;

    typedef struct packed {
        logic        ex;
        logic        eret;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] epc;
        logic        badv_we;
        logic [31:0] badv;
        logic [31:0] rpc;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] rdq[$];
    int          vectors = 0;
    int          errors  = 0;
    int          exp_cnt = 0;

    exc_commit_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_excode(wb_excode),
        .wb_pc(wb_pc), .wb_bd(wb_bd), .wb_badvaddr(wb_badvaddr), .wb_eret(wb_eret),
        .cp0_status(cp0_status), .cp0_cause_ip(cp0_cause_ip), .cp0_epc(cp0_epc),
        .cp0_ex_we(cp0_ex_we), .cp0_eret_we(cp0_eret_we), .cp0_excode(cp0_excode),
        .cp0_bd(cp0_bd), .cp0_epc_wdata(cp0_epc_wdata), .cp0_badv_we(cp0_badv_we),
        .cp0_badvaddr(cp0_badvaddr), .pipeline_flush(pipeline_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .busy(busy), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_count();
`ifdef EXC_CNT_EN
        return 32'(exp_cnt);
`else
        return 32'h0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one WB event for a single accept cycle and queue what CP0/fetch should see.
    task automatic send(input logic ex, input logic [4:0] code, input logic [31:0] pc,
                        input logic bd, input logic [31:0] badv, input logic eret,
                        input logic [31:0] status, input logic [7:0] ip, input logic [31:0] epc);
        exp_t e;
        logic pend;
        pend = status[0] && !status[1] && ((ip & status[15:8]) != 8'd0);
        e = '0;
        if (pend || ex) begin
            e.ex      = 1'b1;
            e.code    = pend ? 5'd0 : code;
            e.bd      = bd;
            e.epc     = bd ? (pc - 32'd4) : pc;
            e.badv_we = !pend && ((code == 5'd4) || (code == 5'd5));
            e.badv    = badv;
            e.rpc     = VEC;
            exp_cnt++;
        end else begin
            e.eret = 1'b1;
            e.rpc  = epc;
        end
        expq.push_back(e);
        wb_ex = ex; wb_excode = code; wb_pc = pc; wb_bd = bd; wb_badvaddr = badv;
        wb_eret = eret; cp0_status = status; cp0_cause_ip = ip; cp0_epc = epc;
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0; wb_ex = 1'b0; wb_eret = 1'b0;
        chk("exc_count", exc_count, model_count());
    endtask

    task automatic flush_window();
        chk1("flush_t1", pipeline_flush, 1'b1);
        chk1("busy_t1", busy, 1'b1);
        chk1("rvalid_t1", redirect_valid, 1'b0);
        for (int i = 1; i < FC; i++) begin
            step();
            chk1("flush_hold", pipeline_flush, 1'b1);
        end
        step();
        chk1("flush_end", pipeline_flush, 1'b0);
        chk1("rvalid_on", redirect_valid, 1'b1);
        chk("strobes_off", {29'd0, cp0_ex_we, cp0_eret_we, cp0_badv_we}, 32'd0);
    endtask

    task automatic take_redirect(input int hold, input logic [31:0] pc);
        for (int i = 0; i < hold; i++) begin
            chk1("rvalid_hold", redirect_valid, 1'b1);
            chk("rpc_hold", redirect_pc, pc);
            step();
        end
        redirect_ready = 1'b1;
        step();
        redirect_ready = 1'b0;
        chk1("rvalid_drop", redirect_valid, 1'b0);
        chk1("busy_drop", busy, 1'b0);
    endtask

    // Scoreboard side: pop on every CP0 strobe and on every completed redirect handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (cp0_ex_we || cp0_eret_we)) begin
            if (expq.size() == 0) begin
                chk("unexpected_strobe", {30'd0, cp0_ex_we, cp0_eret_we}, 32'd0);
            end else begin
                e = expq.pop_front();
                chk1("cp0_ex_we", cp0_ex_we, e.ex);
                chk1("cp0_eret_we", cp0_eret_we, e.eret);
                if (e.ex) begin
                    chk("cp0_excode", 32'(cp0_excode), 32'(e.code));
                    chk1("cp0_bd", cp0_bd, e.bd);
                    chk("cp0_epc_wdata", cp0_epc_wdata, e.epc);
                    chk1("cp0_badv_we", cp0_badv_we, e.badv_we);
                    if (e.badv_we) chk("cp0_badvaddr", cp0_badvaddr, e.badv);
                end else begin
                    chk1("cp0_badv_we_eret", cp0_badv_we, 1'b0);
                end
                rdq.push_back(e.rpc);
            end
        end
        if (!reset && redirect_valid && redirect_ready) begin
            if (rdq.size() == 0) begin
                chk1("unexpected_redirect", redirect_valid, 1'b0);
            end else begin
                chk("redirect_pc", redirect_pc, rdq.pop_front());
            end
        end
    end

    initial begin
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_flush", pipeline_flush, 1'b0);
        chk1("rst_rvalid", redirect_valid, 1'b0);
        chk("rst_rpc", redirect_pc, 32'd0);
        chk("rst_strobes", {29'd0, cp0_ex_we, cp0_eret_we, cp0_badv_we}, 32'd0);
        chk("rst_count", exc_count, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Syscall
        send(1'b1, 5'd8, 32'hBFC00100, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 32'h0);
        flush_window();
        take_redirect(2, VEC);

        // AdEL in a delay slot
        send(1'b1, 5'd4, 32'h00000008, 1'b1, 32'h00000003, 1'b0, 32'h0, 8'h00, 32'h0);
        flush_window();
        take_redirect(1, VEC);

        // Interrupt outranks the syscall, then EXL masks it
        send(1'b1, 5'd8, 32'h00400010, 1'b0, 32'h0, 1'b0, 32'h00008001, 8'h80, 32'h0);
        flush_window();
        take_redirect(1, VEC);
        send(1'b1, 5'd8, 32'h00400010, 1'b0, 32'h0, 1'b0, 32'h00008003, 8'h80, 32'h0);
        flush_window();
        take_redirect(1, VEC);

        // ERET with a stalled fetch
        send(1'b0, 5'd0, 32'h00400020, 1'b0, 32'h0, 1'b1, 32'h00000002, 8'h00, 32'h80001234);
        flush_window();
        take_redirect(5, 32'h80001234);

        // Exception beats a simultaneous ERET
        send(1'b1, 5'd10, 32'h00400030, 1'b0, 32'h0, 1'b1, 32'h0, 8'h00, 32'h80005678);
        flush_window();
        take_redirect(1, VEC);

        // Second exception while busy is dropped
        send(1'b1, 5'd8, 32'h00400040, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 32'h0);
        wb_valid = 1'b1; wb_ex = 1'b1; wb_excode = 5'd12;
        flush_window();
        wb_valid = 1'b0; wb_ex = 1'b0;
        take_redirect(1, VEC);

        // No WB instruction: neither the pending interrupt nor wb_ex is taken
        cp0_status = 32'h00008001; cp0_cause_ip = 8'h80; wb_ex = 1'b1; wb_valid = 1'b0;
        step();
        step();
        chk1("novalid_busy", busy, 1'b0);
        wb_ex = 1'b0; cp0_status = 32'h0; cp0_cause_ip = 8'h0;
        chk("count_final", exc_count, model_count());

        // Reset while the redirect is pending
        send(1'b1, 5'd8, 32'h00400050, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00, 32'h0);
        flush_window();
        #2;
        reset = 1'b1;
        #1;
        chk1("arst_rvalid", redirect_valid, 1'b0);
        chk1("arst_flush", pipeline_flush, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk("arst_count", exc_count, 32'd0);
        rdq.delete();
        exp_cnt = 0;
        step();
        reset = 1'b0;
        step();
        step();
        chk1("post_rst_busy", busy, 1'b0);

        chk("expq_empty", 32'(expq.size()), 32'd0);
        chk("rdq_empty", 32'(rdq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Sequences precise exception, interrupt and ERET commit between the WB stage, the CP0 register block and the fetch stage.
- Arbitrates interrupt, synchronous exception and ERET. Issues one-cycle CP0 write strobes, holds pipeline_flush for a fixed window, then delivers the redirect PC to fetch with a valid/ready handshake.

Parameters:
- EXC_VECTOR, 32'hBFC00380, exception/interrupt entry PC.
- FLUSH_CYCLES, 2, cycles pipeline_flush stays high; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; all state and outputs clear immediately.
- wb_valid  in  1  WB holds a committing instruction.
- wb_ex  in  1  WB instruction carries a synchronous exception.
- wb_excode  in  5  exception code of WB instruction.
- wb_pc  in  32  PC of WB instruction.
- wb_bd  in  1  WB instruction is in a branch delay slot.
- wb_badvaddr  in  32  faulting address for AdEL/AdES.
- wb_eret  in  1  WB instruction is ERET.
- cp0_status  in  32  bit0 IE, bit1 EXL, bits15:8 IM.
- cp0_cause_ip  in  8  pending interrupt lines.
- cp0_epc  in  32  current EPC value.
- cp0_ex_we  out  1  one-cycle exception commit strobe.
- cp0_eret_we  out  1  one-cycle ERET strobe (CP0 clears EXL).
- cp0_excode  out  5  code written to Cause.ExcCode.
- cp0_bd  out  1  value written to Cause.BD.
- cp0_epc_wdata  out  32  EPC value to write.
- cp0_badv_we  out  1  one-cycle BadVAddr write strobe.
- cp0_badvaddr  out  32  BadVAddr value.
- pipeline_flush  out  1  kill all in-flight instructions.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  32  new fetch PC.
- redirect_ready  in  1  fetch accepts the redirect.
- busy  out  1  high in any state other than IDLE.
- exc_count  out  32  accepted exception/interrupt count (see Optional Feature).

Behaviour:
- Reset values: all outputs are 0, state is IDLE.
- States:
  - IDLE: accepts events.
  - FLUSH: pipeline_flush high; counter loaded with FLUSH_CYCLES-1, counts down to 0.
  - REDIRECT: drives the redirect handshake.
- int_pending = IE & ~EXL & |(cp0_cause_ip & IM).
- Event accept (IDLE, wb_valid=1, cycle T); priority is fixed:
  1. int_pending: excode 5'h00, an interrupt attached to the WB instruction.
  2. wb_ex: excode = wb_excode.
  3. wb_eret.
  - If wb_valid=0, nothing is accepted, including interrupts.
- Exception or interrupt accepted at T. In cycle T+1:
  - cp0_ex_we=1 for exactly one cycle.
  - cp0_excode, cp0_bd=wb_bd, and cp0_epc_wdata = wb_bd ? wb_pc-32'd4 : wb_pc (mod 2^32) are registered.
  - cp0_badv_we=1 only when excode is 4 or 5, with cp0_badvaddr=wb_badvaddr.
  - redirect_pc=EXC_VECTOR.
- Strobes are issued regardless of EXL; CP0 itself suppresses the EPC update when EXL=1.
- ERET accepted at T: in T+1, cp0_eret_we=1 for one cycle and redirect_pc = cp0_epc sampled at T.
- Flush window: pipeline_flush is high from T+1 for exactly FLUSH_CYCLES cycles (state FLUSH), then the block enters REDIRECT.
- REDIRECT:
  - redirect_valid=1; redirect_pc is held stable until redirect_ready=1 at a rising edge.
  - Same edge: redirect_valid falls and the block returns to IDLE.
  - redirect_ready while redirect_valid=0 is ignored.
- While busy=1, all WB events and interrupts are ignored (not queued).
- The earliest new accept is the cycle after the block returns to IDLE.
- Simultaneous wb_ex and wb_eret: the exception wins; cp0_eret_we does not pulse.
- Reset asserted mid-operation: immediate return to IDLE, all outputs 0, no strobes are issued afterwards.

Optional Feature:
- Macro: EXC_CNT_EN.
- Defined: exc_count increments by 1 on each accepted exception or interrupt (not ERET), in cycle T+1. It saturates at 32'hFFFFFFFF and is cleared by reset.
- Undefined: the counter logic is not built and exc_count is tied to 32'h0; the port remains.

Test Plan:
- Syscall: wb_valid=1, wb_ex=1, wb_excode=8, wb_pc=32'hBFC00100, wb_bd=0 -> next cycle cp0_ex_we pulse with excode 8 and epc_wdata 32'hBFC00100; flush high 2 cycles; then redirect_valid with 32'hBFC00380, held until ready.
- Delay-slot AdEL: wb_excode=4, wb_bd=1, wb_pc=32'h00000008, badvaddr=32'h00000003 -> epc_wdata 32'h00000004, cp0_bd=1, cp0_badv_we pulse with 32'h00000003.
- Interrupt priority: IE=1, EXL=0, IM=8'h80, IP=8'h80, and WB also carries wb_ex=1 excode 8 -> cp0_excode=0. Repeat with EXL=1 -> the syscall is taken with excode 8.
- ERET: cp0_epc=32'h80001234, wb_eret=1 -> cp0_eret_we pulse, no cp0_ex_we, redirect_pc 32'h80001234. Hold redirect_ready=0 for 5 cycles -> redirect_valid and redirect_pc stay stable.
- Busy masking and reset: a second wb_ex during FLUSH is ignored (single strobe). Asserting reset during REDIRECT clears redirect_valid, pipeline_flush and busy with no clock edge.
- EXC_CNT_EN: 3 exceptions + 1 ERET -> exc_count=3. Built without the macro -> exc_count stays 0.
